wb_bridge_nway: RTL and testbench

- Registered Wishbone bridge that decodes one upward-facing port (UFP) window into NUM_PORTS downward-facing ports (DFPs) by ascending offset regions.
- Successor to the combinational two-way bridge: adds a configurable channel count and a request/response register stage for timing closure.
- Holds a single outstanding transaction and supports abort on cyc drop. An optional timeout recovers from DFPs that never acknowledge.
- Sits between the user-area Wishbone slave interface and the peripheral buses.

---
 rtl/wb_bridge_nway_if.sv | 45 ++++
 rtl/wb_bridge_nway.sv | 171 +++++++++++++++++
 tb/tb_wb_bridge_nway.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_bridge_nway_if.sv
// Wishbone bundle for wb_bridge_nway: one UFP slave port plus NUM_PORTS packed DFP master ports.
// The slave modport is the bridge's view; master is the surrounding system (host + peripherals).
interface wb_bridge_nway_if #(
    parameter int NUM_PORTS      = 4,
    parameter int DFP_ADDR_WIDTH = 24
);
    // Handshake: classic Wishbone. A UFP request is cyc&stb; it completes on a one-cycle ack.
    // Each DFP request holds stb/cyc high until that port's ack is sampled or cyc aborts.
    logic                                wbs_stb_i;
    logic                                wbs_cyc_i;
    logic                                wbs_we_i;
    logic [3:0]                          wbs_sel_i;
    logic [31:0]                         wbs_dat_i;
    logic [31:0]                         wbs_adr_i;
    logic                                wbs_ack_o;
    logic [31:0]                         wbs_dat_o;

    logic [NUM_PORTS-1:0]                wbm_stb_o;
    logic [NUM_PORTS-1:0]                wbm_cyc_o;
    logic [NUM_PORTS-1:0]                wbm_we_o;
    logic [4*NUM_PORTS-1:0]              wbm_sel_o;
    logic [DFP_ADDR_WIDTH*NUM_PORTS-1:0] wbm_adr_o;
    logic [32*NUM_PORTS-1:0]             wbm_dat_o;
    logic [32*NUM_PORTS-1:0]             wbm_dat_i;
    logic [NUM_PORTS-1:0]                wbm_ack_i;

    // Debug view of the bridge FSM (0 IDLE, 1 REQ, 2 RESP).
    logic [1:0]                          state;

    modport slave (
        input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
        output wbs_ack_o, wbs_dat_o,
        output wbm_stb_o, wbm_cyc_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
        input  wbm_dat_i, wbm_ack_i,
        output state
    );

    modport master (
        output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
        input  wbs_ack_o, wbs_dat_o,
        input  wbm_stb_o, wbm_cyc_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
        output wbm_dat_i, wbm_ack_i,
        input  state
    );
endinterface

// File: rtl/wb_bridge_nway.sv
// Registered Wishbone bridge: one UFP window split into NUM_PORTS DFPs by ascending offsets.
// Optional DFP ack timeout is built when WB_BRIDGE_NWAY_TIMEOUT_EN is defined.
module wb_bridge_nway #(
    parameter int                      NUM_PORTS      = 4,
    parameter logic [31:0]             UFP_BASE_ADDR  = 32'h3000_0000,
    parameter logic [31:0]             UFP_BASE_MASK  = 32'hff00_0000,
    parameter logic [32*NUM_PORTS-1:0] PORT_OFFSETS   = {32'h00ff_fc00, 32'h0080_0000,
                                                         32'h0040_0000, 32'h0000_0000},
    parameter int                      DFP_ADDR_WIDTH = 24,
    parameter int                      TIMEOUT_CYCLES = 255
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_i,
    wb_bridge_nway_if.slave bus,
    output logic            timeout_o
);
    localparam int PW = $clog2(NUM_PORTS);

    if (NUM_PORTS < 2 || NUM_PORTS > 8 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535)
    begin : g_bad_params
        $error("wb_bridge_nway: parameter out of range");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                    state;
    state_t                    state_nxt;

    logic [31:0]               local_adr;
    logic                      hit;
    logic [PW-1:0]             dec_port;
    logic [DFP_ADDR_WIDTH-1:0] dec_adr;

    logic [PW-1:0]             req_port;
    logic [DFP_ADDR_WIDTH-1:0] req_adr;
    logic [31:0]               req_dat;
    logic [3:0]                req_sel;
    logic                      req_we;
    logic [31:0]               resp_dat;

    logic                      sel_ack;
    logic                      timeout_hit;

    assign local_adr = bus.wbs_adr_i & ~UFP_BASE_MASK;
    assign hit       = bus.wbs_cyc_i && bus.wbs_stb_i &&
                       ((bus.wbs_adr_i & UFP_BASE_MASK) == UFP_BASE_ADDR);
    assign sel_ack   = bus.wbm_ack_i[req_port];
    assign bus.state = state;

    // Offsets ascend, so the last region whose start is <= local wins.
    always_comb begin
        dec_port = '0;
        dec_adr  = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (local_adr >= PORT_OFFSETS[i*32 +: 32]) begin
                dec_port = PW'(i);
                dec_adr  = DFP_ADDR_WIDTH'(local_adr - PORT_OFFSETS[i*32 +: 32]);
            end
        end
    end

`ifdef WB_BRIDGE_NWAY_TIMEOUT_EN
    logic [15:0] to_cnt;
    logic        resp_timeout;

    // A DFP ack on the limit cycle takes priority over the timeout.
    assign timeout_hit = (to_cnt == 16'(TIMEOUT_CYCLES)) && !sel_ack;
    assign timeout_o   = (state == RESP) && resp_timeout;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            to_cnt       <= '0;
            resp_timeout <= 1'b0;
        end else begin
            if (state == IDLE && hit) begin
                to_cnt <= '0;
            end else if (state == REQ && !sel_ack) begin
                to_cnt <= to_cnt + 16'd1;
            end
            resp_timeout <= (state == REQ) && bus.wbs_cyc_i && timeout_hit;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign timeout_o   = 1'b0;
`endif

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A cyc drop in REQ aborts even if the DFP acks in the same cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (hit) begin
                    state_nxt = REQ;
                end
            end
            REQ: begin
                if (!bus.wbs_cyc_i) begin
                    state_nxt = IDLE;
                end else if (sel_ack || timeout_hit) begin
                    state_nxt = RESP;
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            req_port <= '0;
            req_adr  <= '0;
            req_dat  <= '0;
            req_sel  <= '0;
            req_we   <= 1'b0;
            resp_dat <= '0;
        end else if (state == IDLE && hit) begin
            req_port <= dec_port;
            req_adr  <= dec_adr;
            req_dat  <= bus.wbs_dat_i;
            req_sel  <= bus.wbs_sel_i;
            req_we   <= bus.wbs_we_i;
        end else if (state == REQ && bus.wbs_cyc_i) begin
            if (sel_ack) begin
                resp_dat <= bus.wbm_dat_i[int'(req_port)*32 +: 32];
            end else if (timeout_hit) begin
                resp_dat <= 32'hDEAD_BEEF;
            end
        end
    end

    // Unselected slices stay zero so a DFP never sees stale address/data.
    always_comb begin
        bus.wbm_stb_o = '0;
        bus.wbm_cyc_o = '0;
        bus.wbm_we_o  = '0;
        bus.wbm_sel_o = '0;
        bus.wbm_adr_o = '0;
        bus.wbm_dat_o = '0;
        bus.wbs_ack_o = 1'b0;
        bus.wbs_dat_o = '0;
        case (state)
            REQ: begin
                bus.wbm_stb_o[req_port]                                   = 1'b1;
                bus.wbm_cyc_o[req_port]                                   = 1'b1;
                bus.wbm_we_o[req_port]                                    = req_we;
                bus.wbm_sel_o[int'(req_port)*4 +: 4]                      = req_sel;
                bus.wbm_adr_o[int'(req_port)*DFP_ADDR_WIDTH +: DFP_ADDR_WIDTH] = req_adr;
                bus.wbm_dat_o[int'(req_port)*32 +: 32]                    = req_dat;
            end
            RESP: begin
                bus.wbs_ack_o = 1'b1;
                bus.wbs_dat_o = resp_dat;
            end
            default: begin
            end
        endcase
    end
endmodule

// File: tb/tb_wb_bridge_nway.sv
// Directed bench for wb_bridge_nway: read/write per region, boundaries, miss, abort, reset, timeout.
// Expected UFP read data is queued at request time and popped when wbs_ack_o is observed.
module tb_wb_bridge_nway;
    localparam int NP = 4;
    localparam int AW = 24;

    logic clk = 1'b0;
    logic rst;
    logic timeout;
    int   tests = 0;
    int   fails = 0;
    logic [31:0] exp_q[$];

    wb_bridge_nway_if #(.NUM_PORTS(NP), .DFP_ADDR_WIDTH(AW)) bus ();

    wb_bridge_nway #(
        .NUM_PORTS(NP),
        .DFP_ADDR_WIDTH(AW),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .bus      (bus),
        .timeout_o(timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired before summary");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ufp_idle();
        bus.wbs_cyc_i = 1'b0;
        bus.wbs_stb_i = 1'b0;
        bus.wbs_we_i  = 1'b0;
        bus.wbs_sel_i = '0;
        bus.wbs_dat_i = '0;
        bus.wbs_adr_i = '0;
    endtask

    task automatic ufp_req(input logic [31:0] adr, input logic we, input logic [31:0] dat,
                           input logic [3:0] sel);
        bus.wbs_adr_i = adr;
        bus.wbs_we_i  = we;
        bus.wbs_dat_i = dat;
        bus.wbs_sel_i = sel;
        bus.wbs_cyc_i = 1'b1;
        bus.wbs_stb_i = 1'b1;
    endtask

    task automatic check_dfp_idle(input string tag);
        check({tag, "_stb"}, bus.wbm_stb_o, '0);
        check({tag, "_cyc"}, bus.wbm_cyc_o, '0);
        check({tag, "_adr"}, bus.wbm_adr_o, '0);
        check({tag, "_dat"}, bus.wbm_dat_o, '0);
    endtask

    task automatic check_dfp_sel(input string tag, input int port, input logic we,
                                 input logic [3:0] sel, input logic [AW-1:0] adr,
                                 input logic [31:0] dat);
        logic [NP-1:0]    one;
        logic [4*NP-1:0]  sv;
        logic [AW*NP-1:0] av;
        logic [32*NP-1:0] dv;
        one = '0;
        sv  = '0;
        av  = '0;
        dv  = '0;
        one[port]         = 1'b1;
        sv[port*4 +: 4]   = sel;
        av[port*AW +: AW] = adr;
        dv[port*32 +: 32] = dat;
        check({tag, "_stb"}, bus.wbm_stb_o, one);
        check({tag, "_cyc"}, bus.wbm_cyc_o, one);
        check({tag, "_we"},  bus.wbm_we_o, we ? one : '0);
        check({tag, "_sel"}, bus.wbm_sel_o, sv);
        check({tag, "_adr"}, bus.wbm_adr_o, av);
        check({tag, "_dat"}, bus.wbm_dat_o, dv);
    endtask

    // Full transaction: request, `delay` REQ cycles with a stray ack, then selected ack.
    task automatic do_txn(input string tag, input logic [31:0] adr, input logic we,
                          input logic [31:0] wdat, input logic [3:0] sel, input int port,
                          input logic [AW-1:0] exp_adr, input logic [31:0] rdat,
                          input int delay);
        ufp_req(adr, we, wdat, sel);
        tick();
        check_dfp_sel({tag, "_req"}, port, we, sel, exp_adr, wdat);
        check({tag, "_req_noack"}, bus.wbs_ack_o, 1'b0);
        exp_q.push_back(rdat);
        bus.wbs_adr_i = adr ^ 32'h0000_0ff0;
        bus.wbs_dat_i = ~wdat;
        bus.wbs_sel_i = ~sel;
        for (int d = 0; d < delay; d++) begin
            bus.wbm_ack_i = 4'b0001 << ((port + 1) % NP);
            bus.wbm_dat_i = {$urandom, $urandom, $urandom, $urandom};
            tick();
            check_dfp_sel({tag, "_hold"}, port, we, sel, exp_adr, wdat);
            check({tag, "_hold_noack"}, bus.wbs_ack_o, 1'b0);
        end
        bus.wbm_dat_i = {$urandom, $urandom, $urandom, $urandom};
        bus.wbm_dat_i[port*32 +: 32] = rdat;
        bus.wbm_ack_i = 4'b0001 << port;
        tick();
        bus.wbm_ack_i = '0;
        bus.wbm_dat_i = '0;
        check({tag, "_ack"}, bus.wbs_ack_o, 1'b1);
        check({tag, "_rdat"}, bus.wbs_dat_o, exp_q.pop_front());
        check({tag, "_to"}, timeout, 1'b0);
        check_dfp_idle({tag, "_resp"});
        ufp_idle();
        tick();
        check({tag, "_one_ack"}, bus.wbs_ack_o, 1'b0);
        check({tag, "_dat_zero"}, bus.wbs_dat_o, 32'h0);
    endtask

    task automatic abort_txn(input string tag, input logic with_ack);
        ufp_req(32'h3040_0100, 1'b0, 32'h0, 4'hf);
        tick();
        check({tag, "_cyc1"}, bus.wbm_cyc_o, 4'b0010);
        check({tag, "_adr1"}, bus.wbm_adr_o[1*AW +: AW], 24'h000100);
        ufp_idle();
        if (with_ack) begin
            bus.wbm_ack_i = 4'b0010;
            bus.wbm_dat_i[32 +: 32] = 32'h7777_0001;
        end
        tick();
        bus.wbm_ack_i = '0;
        bus.wbm_dat_i = '0;
        check_dfp_idle({tag, "_drop"});
        check({tag, "_noack0"}, bus.wbs_ack_o, 1'b0);
        tick();
        check({tag, "_noack1"}, bus.wbs_ack_o, 1'b0);
        check_dfp_idle({tag, "_stay"});
    endtask

    initial begin
        rst = 1'b1;
        ufp_idle();
        bus.wbm_ack_i = '0;
        bus.wbm_dat_i = '0;
        #1;
        check("rst_ack", bus.wbs_ack_o, 1'b0);
        check("rst_dat", bus.wbs_dat_o, 32'h0);
        check("rst_to", timeout, 1'b0);
        check("rst_state", bus.state, 2'd0);
        check_dfp_idle("rst");
        tick();
        tick();
        rst = 1'b0;
        tick();

        do_txn("rd_p0", 32'h3000_0010, 1'b0, 32'h0, 4'hf, 0, 24'h000010, 32'h1234_5678, 0);
        do_txn("wr_p3", 32'h30ff_fc08, 1'b1, 32'ha5a5_0001, 4'h3, 3, 24'h000008, 32'h0, 2);
        do_txn("bnd_p0", 32'h303f_fffc, 1'b0, 32'h0, 4'hf, 0, 24'h3ffffc, 32'hcafe_0000, 1);
        do_txn("bnd_p1", 32'h3040_0000, 1'b0, 32'h0, 4'hf, 1, 24'h000000, 32'hcafe_0001, 0);
        do_txn("rd_p2", 32'h3080_0040, 1'b0, 32'h0, 4'h1, 2, 24'h000040, 32'h0bad_c0de, 3);
        do_txn("bnd_p2", 32'h30ff_fbfc, 1'b1, 32'h5a5a_5a5a, 4'hc, 2, 24'h7ffbfc, 32'h0, 0);

        ufp_req(32'h2000_0000, 1'b0, 32'h0, 4'hf);
        for (int c = 0; c < 10; c++) begin
            tick();
            check("miss_stb", bus.wbm_stb_o, 4'b0000);
            check("miss_ack", bus.wbs_ack_o, 1'b0);
        end
        ufp_idle();
        tick();

        abort_txn("abort", 1'b0);
        abort_txn("abort_ack", 1'b1);

`ifdef WB_BRIDGE_NWAY_TIMEOUT_EN
        ufp_req(32'h3080_0040, 1'b0, 32'h0, 4'hf);
        tick();
        exp_q.push_back(32'hdead_beef);
        for (int k = 1; k <= 4; k++) begin
            tick();
            check("to_wait_stb", bus.wbm_stb_o, 4'b0100);
            check("to_wait_pulse", timeout, 1'b0);
            check("to_wait_ack", bus.wbs_ack_o, 1'b0);
        end
        tick();
        check("to_ack", bus.wbs_ack_o, 1'b1);
        check("to_dat", bus.wbs_dat_o, exp_q.pop_front());
        check("to_pulse", timeout, 1'b1);
        check("to_stb", bus.wbm_stb_o, 4'b0000);
        ufp_idle();
        tick();
        check("to_pulse_end", timeout, 1'b0);
        check("to_one_ack", bus.wbs_ack_o, 1'b0);

        ufp_req(32'h3080_0044, 1'b0, 32'h0, 4'hf);
        tick();
        exp_q.push_back(32'h0bad_f00d);
        for (int k = 1; k <= 4; k++) begin
            tick();
        end
        check("lim_stb", bus.wbm_stb_o, 4'b0100);
        bus.wbm_ack_i = 4'b0100;
        bus.wbm_dat_i[64 +: 32] = 32'h0bad_f00d;
        tick();
        bus.wbm_ack_i = '0;
        bus.wbm_dat_i = '0;
        check("lim_ack", bus.wbs_ack_o, 1'b1);
        check("lim_dat", bus.wbs_dat_o, exp_q.pop_front());
        check("lim_no_to", timeout, 1'b0);
        ufp_idle();
        tick();
        check("lim_no_to_after", timeout, 1'b0);
`else
        ufp_req(32'h3080_0040, 1'b0, 32'h0, 4'hf);
        for (int k = 0; k < 8; k++) begin
            tick();
            check("wait_stb", bus.wbm_stb_o, 4'b0100);
            check("wait_to", timeout, 1'b0);
            check("wait_ack", bus.wbs_ack_o, 1'b0);
        end
        ufp_idle();
        tick();
        check_dfp_idle("wait_abort");
        tick();
`endif

        ufp_req(32'h30ff_fd00, 1'b1, 32'h1111_2222, 4'hf);
        tick();
        check("rstmid_cyc", bus.wbm_cyc_o, 4'b1000);
        #2;
        rst = 1'b1;
        #1;
        check_dfp_idle("rstmid");
        check("rstmid_ack", bus.wbs_ack_o, 1'b0);
        ufp_idle();
        tick();
        rst = 1'b0;
        tick();
        check("rstmid_noack", bus.wbs_ack_o, 1'b0);
        check_dfp_idle("rstmid_after");
        do_txn("post_rst", 32'h3000_0020, 1'b0, 32'h0, 4'hf, 0, 24'h000020, 32'h8765_4321, 1);

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
